// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - round-robin arbiter sharing one DRAM port between NUM_REQ requesters
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_wen/req_lock [NUM_REQ]  per-requester command valid, write flag, burst-lock request
//   req_addr  [NUM_REQ*ADDR_W]            packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   req_wdata [NUM_REQ*DATA_W]            packed write data
//   req_ready [NUM_REQ]                   one-hot accept (combinational)
//   rsp_valid [NUM_REQ], rsp_data         one-hot read return, shared data bus
//   dram_en/dram_wen/dram_addr/dram_wdata registered DRAM command, dram_rdata read data in
//   busy                                  reads in flight or arbiter not idle
//
// Optional feature macro: DRAM_ARB_WRITE_PRIO_EN (writes outrank reads outside a locked burst).
module dram_port_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 2,
    parameter int BURST_MAX = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_wen,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        dram_en,
    output logic                        dram_wen,
    output logic [ADDR_W-1:0]           dram_addr,
    output logic [DATA_W-1:0]           dram_wdata,
    input  logic [DATA_W-1:0]           dram_rdata,
    output logic                        busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {IDLE, ARB, LOCKED} state_t;

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     rr_ptr, owner, winner, acc_id;
    logic [SUM_W-1:0]     idx_sum;
    logic                 win_found, lock_win, accept, pipe_any;
    logic [NUM_REQ-1:0]   eligible, others;
    logic [CNT_W-1:0]     beat_cnt;
    logic [NUM_REQ-1:0]   tag_pipe [0:RD_LAT];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_REQ - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

`ifdef DRAM_ARB_WRITE_PRIO_EN
    // Any pending write masks out all reads; round-robin then runs over writes only.
    assign eligible = (|(req_valid & req_wen)) ? (req_valid & req_wen) : req_valid;
`else
    assign eligible = req_valid;
`endif

    // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        idx_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_sum = {1'b0, rr_ptr} + SUM_W'(i);
            if (idx_sum >= SUM_W'(NUM_REQ)) idx_sum = idx_sum - SUM_W'(NUM_REQ);
            if (!win_found && eligible[idx_sum[PTR_W-1:0]]) begin
                win_found = 1'b1;
                winner    = idx_sum[PTR_W-1:0];
            end
        end
    end

    // A single-beat burst limit makes locking meaningless, so the lock is ignored then.
    assign lock_win = win_found && req_lock[winner] && (BURST_MAX > 1);

    always_comb begin
        others         = req_valid;
        others[winner] = 1'b0;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; IDLE also arbitrates so a fresh request is taken the cycle it appears.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (win_found) state_nxt = lock_win ? LOCKED : ARB;
            end
            ARB: begin
                if (!win_found)     state_nxt = IDLE;
                else if (lock_win)  state_nxt = LOCKED;
                else if (|others)   state_nxt = ARB;
                else                state_nxt = IDLE;
            end
            LOCKED: begin
                // Release on drop of valid/lock, or on the beat that reaches BURST_MAX.
                if (!req_valid[owner] || !req_lock[owner] ||
                    beat_cnt == CNT_W'(BURST_MAX - 1))
                    state_nxt = ARB;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: one-hot ready, held low while reset is asserted.
    always_comb begin
        req_ready = '0;
        case (state)
            IDLE, ARB: if (win_found) req_ready[winner] = 1'b1;
            LOCKED:    req_ready[owner] = req_valid[owner];
            default:   req_ready = '0;
        endcase
        if (!reset) req_ready = '0;
    end

    assign accept = |req_ready;
    assign acc_id = (state == LOCKED) ? owner : winner;

    // rr_ptr already points past the owner while locked, so release needs no update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else if (state != LOCKED) begin
            if (win_found) begin
                rr_ptr <= ptr_inc(winner);
                if (lock_win) begin
                    owner    <= winner;
                    beat_cnt <= CNT_W'(1);
                end
            end
        end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    // Registered DRAM command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dram_en    <= 1'b0;
            dram_wen   <= 1'b0;
            dram_addr  <= '0;
            dram_wdata <= '0;
        end else begin
            dram_en  <= accept;
            dram_wen <= accept & req_wen[acc_id];
            if (accept) begin
                dram_addr  <= req_addr[int'(acc_id)*ADDR_W +: ADDR_W];
                dram_wdata <= req_wdata[int'(acc_id)*DATA_W +: DATA_W];
            end
        end
    end

    // Tag pipe: stage 0 loads alongside the command register, so the tail lines up
    // with dram_rdata RD_LAT cycles after dram_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= RD_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= req_ready & ~req_wen;
            for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_comb begin
        pipe_any = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) pipe_any = pipe_any | (|tag_pipe[i]);
    end

    assign rsp_valid = tag_pipe[RD_LAT];
    assign rsp_data  = (|rsp_valid) ? dram_rdata : '0;
    assign busy      = pipe_any || (state != IDLE);

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - self-checking bench for dram_port_arbiter
module tb_dram_port_arbiter;

    localparam int NUM_REQ   = 3;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int RD_LAT    = 2;
    localparam int BURST_MAX = 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid, req_wen, req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready, rsp_valid;
    logic [DATA_W-1:0]         rsp_data, dram_wdata, dram_rdata;
    logic                      dram_en, dram_wen, busy;
    logic [ADDR_W-1:0]         dram_addr;

    dram_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .RD_LAT(RD_LAT), .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_wen(req_wen), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .dram_en(dram_en), .dram_wen(dram_wen), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_rdata(dram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid, wen, lock;
        logic [47:0] addr, wdata;
        logic [2:0]  exp_ready;
        logic        chk_busy, exp_busy;
    } vec_t;

    typedef struct { int due; logic wen; logic [15:0] addr; logic [15:0] wdata; } cmd_t;
    typedef struct { int due; logic [2:0] tag; } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    vec_t vecs[20];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

`ifdef DRAM_ARB_WRITE_PRIO_EN
    localparam logic [2:0] EXP_V14 = 3'b001;
    localparam logic [2:0] PRIO_A  = 3'b100;
    localparam logic [2:0] PRIO_B  = 3'b001;
`else
    localparam logic [2:0] EXP_V14 = 3'b010;
    localparam logic [2:0] PRIO_A  = 3'b001;
    localparam logic [2:0] PRIO_B  = 3'b100;
`endif

    function automatic vec_t mk(input logic [2:0] va, input logic [2:0] we, input logic [2:0] lk,
                                input logic [47:0] ad, input logic [47:0] wd,
                                input logic [2:0] ex, input logic cb, input logic eb);
        vec_t v;
        v.valid = va; v.wen = we; v.lock = lk; v.addr = ad; v.wdata = wd;
        v.exp_ready = ex; v.chk_busy = cb; v.exp_busy = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check combinational and registered outputs, score, advance.
    task automatic run_cycle(input vec_t v);
        cmd_t       c;
        rsp_t       r;
        logic [2:0] tag;
        logic [15:0] rd;
        req_valid = v.valid; req_wen = v.wen; req_lock = v.lock;
        req_addr  = v.addr;  req_wdata = v.wdata;
        rd = 16'(32'hA000 + cyc);
        dram_rdata = rd;
        #3;
        check("req_ready", 64'(req_ready), 64'(v.exp_ready));
        if (v.chk_busy) check("busy", 64'(busy), 64'(v.exp_busy));
        if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
            c = cmd_q.pop_front();
            check("dram_en", 64'(dram_en), 64'd1);
            check("dram_wen", 64'(dram_wen), 64'(c.wen));
            check("dram_addr", 64'(dram_addr), 64'(c.addr));
            if (c.wen) check("dram_wdata", 64'(dram_wdata), 64'(c.wdata));
        end else begin
            check("dram_en_idle", 64'(dram_en), 64'd0);
        end
        tag = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            r = rsp_q.pop_front();
            tag = r.tag;
        end
        check("rsp_valid", 64'(rsp_valid), 64'(tag));
        if (tag != 3'b000) check("rsp_data", 64'(rsp_data), 64'(rd));
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v.exp_ready[k]) begin
                c.due = cyc + 1; c.wen = v.wen[k];
                c.addr = v.addr[k*16 +: 16]; c.wdata = v.wdata[k*16 +: 16];
                cmd_q.push_back(c);
                if (!v.wen[k]) begin
                    r.due = cyc + 1 + RD_LAT;
                    r.tag = '0;
                    r.tag[k] = 1'b1;
                    rsp_q.push_back(r);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req_valid = 3'b011; req_wen = 3'b000; req_lock = 3'b011;
        #3;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_dram_en", 64'(dram_en), 64'd0);
        check("rst_dram_wen", 64'(dram_wen), 64'd0);
        check("rst_dram_addr", 64'(dram_addr), 64'd0);
        check("rst_dram_wdata", 64'(dram_wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        cmd_q.delete();
        rsp_q.delete();
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
        req_valid = '0; req_lock = '0;
    endtask

    task automatic idle(input int n, input logic chk_last);
        for (int i = 0; i < n; i++)
            run_cycle(mk(3'b000, 3'b000, 3'b000, 48'h0, 48'h0, 3'b000,
                         chk_last && (i == n - 1), 1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        // Round robin on three reads, then an idle gap.
        for (int i = 0; i < 6; i++)
            vecs[i] = mk(3'b111, 3'b000, 3'b000, 48'h0030_0020_0010, 48'h0,
                         3'(1 << (i % 3)), i == 0, 1'b0);
        for (int i = 6; i < 11; i++)
            vecs[i] = mk(3'b000, 3'b000, 3'b000, 48'h0, 48'h0, 3'b000,
                         (i == 6) || (i == 10), i == 6);
        // Write from requester 2, accepted the cycle it is presented after the gap.
        vecs[11] = mk(3'b100, 3'b100, 3'b000, 48'h0005_0000_0000, 48'hBEEF_0000_0000, 3'b100, 1'b0, 1'b0);
        vecs[12] = mk(3'b000, 3'b000, 3'b000, 48'h0, 48'h0, 3'b000, 1'b0, 1'b0);
        // Write from 0 and read from 1 competing.
        vecs[13] = mk(3'b011, 3'b001, 3'b000, 48'h0000_0200_0100, 48'h0000_0000_1234, 3'b001, 1'b0, 1'b0);
        vecs[14] = mk(3'b011, 3'b001, 3'b000, 48'h0000_0200_0100, 48'h0000_0000_1234, EXP_V14, 1'b0, 1'b0);
        for (int i = 15; i < 20; i++)
            vecs[i] = mk(3'b000, 3'b000, 3'b000, 48'h0, 48'h0, 3'b000, i == 19, 1'b0);

        reset = 1'b0;
        req_valid = '0; req_wen = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0; dram_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        for (int i = 0; i < 20; i++) run_cycle(vecs[i]);

        // Reset with two reads in flight: no response may ever appear.
        run_cycle(mk(3'b001, 3'b000, 3'b000, 48'h0000_0000_0111, 48'h0, 3'b001, 1'b0, 1'b0));
        run_cycle(mk(3'b010, 3'b000, 3'b000, 48'h0000_0222_0000, 48'h0, 3'b010, 1'b0, 1'b0));
        apply_reset();
        for (int i = 0; i < 5; i++)
            run_cycle(mk(3'b000, 3'b000, 3'b000, 48'h0, 48'h0, 3'b000, 1'b1, 1'b0));

        // Read 0 versus write 2 with rr_ptr at 0.
        run_cycle(mk(3'b101, 3'b100, 3'b000, 48'h0022_0000_0011, 48'h5555_0000_0000, PRIO_A, 1'b0, 1'b0));
        run_cycle(mk(PRIO_B, 3'b100, 3'b000, 48'h0022_0000_0011, 48'h5555_0000_0000, PRIO_B, 1'b0, 1'b0));
        idle(4, 1'b1);

        // Locked burst from requester 1 with forced release at BURST_MAX.
        apply_reset();
        for (int n = 0; n < BURST_MAX; n++)
            run_cycle(mk((n == 0) ? 3'b010 : 3'b011, 3'b000, 3'b010,
                         {16'h0000, 16'(16'h0400 + n), 16'h0AAA}, 48'h0, 3'b010, 1'b0, 1'b0));
        run_cycle(mk(3'b011, 3'b000, 3'b010, {16'h0000, 16'h0408, 16'h0AAA}, 48'h0, 3'b001, 1'b0, 1'b0));
        run_cycle(mk(3'b011, 3'b000, 3'b010, {16'h0000, 16'h0408, 16'h0AAA}, 48'h0, 3'b010, 1'b0, 1'b0));
        run_cycle(mk(3'b011, 3'b000, 3'b000, {16'h0000, 16'h0409, 16'h0AAA}, 48'h0, 3'b010, 1'b0, 1'b0));
        run_cycle(mk(3'b001, 3'b000, 3'b000, {16'h0000, 16'h0000, 16'h0AAA}, 48'h0, 3'b001, 1'b0, 1'b0));
        idle(5, 1'b1);

        check("sb_cmd_drained", 64'(cmd_q.size()), 64'd0);
        check("sb_rsp_drained", 64'(rsp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single off-chip DRAM port between NUM_REQ requesters, e.g. the CNN controller's activation-read, weight-read and result-write channels.
- Arbitration is round-robin, with optional burst lock so a requester can hold the port for back-to-back sequential beats.
- The DRAM command is registered on the way out; read data is returned to the issuing requester through a tag pipeline matched to the fixed DRAM read latency.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- ADDR_W, 16: DRAM address width, equal to `DRAMA_DIM.
- DATA_W, 16: DRAM data width.
- RD_LAT, 2: cycles from dram_en (read) to dram_rdata valid (>=1).
- BURST_MAX, 8: maximum consecutive beats granted to one locked requester.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  NUM_REQ  per-requester command valid.
- req_wen  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  request to keep the grant for the next beat.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies bits [k*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot accept; a command transfers when valid&ready.
- rsp_valid  out  NUM_REQ  one-hot read-data valid.
- rsp_data  out  DATA_W  read data (shared bus).
- dram_en  out  1  DRAM command strobe.
- dram_wen  out  1  DRAM write enable.
- dram_addr  out  ADDR_W  DRAM address.
- dram_wdata  out  DATA_W  DRAM write data.
- dram_rdata  in  DATA_W  DRAM read data.
- busy  out  1  any read outstanding in the tag pipe, or state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0. rr_ptr=0, state=IDLE, beat_cnt=0, tag pipe cleared. No rsp_valid is ever produced for reads issued before a reset; this holds for resets mid-burst and with reads in flight.
- FSM states: IDLE, ARB, LOCKED.
  - IDLE -> ARB when any req_valid.
  - ARB: winner = first valid requester scanning from rr_ptr upward, modulo NUM_REQ. req_ready[winner]=1 combinationally in the same cycle. rr_ptr <= winner+1 (wraps NUM_REQ-1 -> 0).
    - If req_lock[winner]: go to LOCKED, owner<=winner, beat_cnt<=1.
    - Otherwise stay in ARB, or go to IDLE if no other valid exists.
  - LOCKED: only the owner is eligible. req_ready[owner]=req_valid[owner]; beat_cnt increments on each accept.
    - Exit to ARB when the owner deasserts req_valid or req_lock, or after the accept that makes beat_cnt==BURST_MAX (forced release).
    - On exit, rr_ptr=owner+1, so the owner cannot win the very next cycle if another requester is valid.
- Command timing: a command accepted in cycle t appears on dram_en/dram_wen/dram_addr/dram_wdata in cycle t+1. Throughput is 1 beat/cycle, with no bubble between different winners.
- Reads: a tag (one-hot requester id) enters a RD_LAT+1 deep shift pipe when dram_en=1 and dram_wen=0.
  - rsp_valid = pipe tail; rsp_data = dram_rdata, combinational passthrough.
  - Total latency from accept to rsp_valid is 1+RD_LAT cycles.
  - Responses return in issue order. Requesters must accept responses unconditionally (no back-pressure).
- Writes: no response; dram_wen=1 for one cycle.
- Simultaneous events: the lowest index at or after rr_ptr wins. A write and a read from different requesters are never merged.
- req_ready is never asserted for a requester whose req_valid is 0. At most one req_ready bit is high.

Optional Feature:
- DRAM_ARB_WRITE_PRIO_EN
  - Defined: in ARB, any valid write outranks all reads; round-robin among writes only, and rr_ptr is updated as normal. LOCKED is unaffected.
  - Undefined: pure round-robin regardless of req_wen.

Test Plan:
- Reset, then req_valid=3'b111 held, all reads, no lock, addrs 0x10/0x20/0x30 -> grants 0,1,2,0,... one per cycle. dram_addr sequence 0x10,0x20,0x30 starting the cycle after the first accept. rsp_valid 001,010,100 starting at accept+3 (RD_LAT=2).
- Requester 1 locked reads at 0x0400..0x0409 while requester 0 is valid -> requester 1 gets exactly 8 beats (0x0400..0x0407), then requester 0 is granted, then requester 1 resumes at 0x0408.
- Requester 2 write addr 0x0005 data 0xBEEF -> dram_en=1, dram_wen=1, dram_addr=0x0005, dram_wdata=0xBEEF one cycle after accept; no rsp_valid follows.
- Two reads in flight, then reset pulsed low for 1 cycle -> all outputs 0 immediately, rsp_valid stays 0 afterwards, busy=0.
- With DRAM_ARB_WRITE_PRIO_EN: rr_ptr=0, req0 read and req2 write valid together -> req2 granted first. Without the macro -> req0 granted first.
- Idle gap: req_valid=0 for 5 cycles -> dram_en=0, busy=0 after the last response, state returns to IDLE. Next request is accepted the same cycle it is presented.
